// File: rtl/lsosc_pkg.sv
// Shared types and defaults for the behavioural low-frequency oscillator model.
// States, default divider/settling constants and a counter width helper.
package lsosc_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_STARTUP = 2'd1,
    ST_RUN     = 2'd2
  } lsosc_state_t;

  // 48 MHz reference: 2400 cycles per half-period gives 10 kHz, 4800 cycles is 100 us.
  localparam int DIV_HALF_DEF = 2400;
  localparam int PU_DELAY_DEF = 4800;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsosc_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lsosc.sv
// Low-frequency oscillator model: divides the reference clock down to CLKLF after
// a power-up settling delay, with an enable that only ever gates whole high pulses.
module lsosc
  import lsosc_pkg::*;
#(
  parameter int DIV_HALF = DIV_HALF_DEF,
  parameter int PU_DELAY = PU_DELAY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic CLKLFPU,
  input  logic CLKLFEN,
  output logic CLKLF,
  output logic lf_ready
);

  localparam int DW = cnt_width(DIV_HALF);
  localparam int PW = cnt_width(PU_DELAY);
  localparam logic [DW-1:0] DIV_TC = DW'(DIV_HALF - 1);
  localparam logic [PW-1:0] PU_TC  = PW'(PU_DELAY - 1);

  logic pu_s;
  logic en_s;

  lsosc_state_t  state, state_d;
  logic [PW-1:0] pu_cnt, pu_cnt_d;
  logic [DW-1:0] div_cnt, div_cnt_d;
  logic          phase, phase_d;
  logic          gate_en, gate_en_d;
  logic          ready_d;
  logic          clklf_d;

  sync_2ff u_sync_pu (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (CLKLFPU),
    .q     (pu_s)
  );

  sync_2ff u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (CLKLFEN),
    .q     (en_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      pu_cnt   <= '0;
      div_cnt  <= '0;
      phase    <= 1'b0;
      gate_en  <= 1'b0;
      lf_ready <= 1'b0;
      CLKLF    <= 1'b0;
    end else begin
      state    <= state_d;
      pu_cnt   <= pu_cnt_d;
      div_cnt  <= div_cnt_d;
      phase    <= phase_d;
      gate_en  <= gate_en_d;
      lf_ready <= ready_d;
      CLKLF    <= clklf_d;
    end
  end

  // Everything defaults to the OFF values, so leaving RUN/STARTUP clears all state.
  always_comb begin
    state_d   = state;
    pu_cnt_d  = '0;
    div_cnt_d = '0;
    phase_d   = 1'b0;
    gate_en_d = 1'b0;
    ready_d   = 1'b0;

    case (state)
      ST_OFF: begin
        if (pu_s) state_d = ST_STARTUP;
      end
      ST_STARTUP: begin
        if (!pu_s) begin
          state_d = ST_OFF;
        end else if (pu_cnt == PU_TC) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          pu_cnt_d = pu_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!pu_s) begin
          state_d = ST_OFF;
        end else begin
          ready_d   = 1'b1;
          phase_d   = phase;
          gate_en_d = gate_en;
          if (div_cnt == DIV_TC) begin
            phase_d = ~phase;
            // Enable is sampled only at a rising phase so a pulse is never cut short.
            if (!phase) gate_en_d = en_s;
          end else begin
            div_cnt_d = div_cnt + 1'b1;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    clklf_d = phase_d & gate_en_d;
  end

endmodule

// File: tb/tb_lsosc.sv
// Directed bench for lsosc with DIV_HALF=4, PU_DELAY=8; edge numbers in comments
// count rising clk edges after the inputs change at a falling edge.
module tb_lsosc;
  import lsosc_pkg::*;

  logic clk;
  logic rst_n;
  logic pu;
  logic en;
  logic clklf;
  logic lf_ready;

  int checks = 0;
  int errors = 0;

  lsosc #(
    .DIV_HALF (4),
    .PU_DELAY (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .CLKLFPU  (pu),
    .CLKLFEN  (en),
    .CLKLF    (clklf),
    .lf_ready (lf_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: each call passes exactly one rising edge per count, ending on a falling edge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_ck;
    logic exp_lf;
    int   ph;
    int   r;

    rst_n = 1'b0;
    pu    = 1'b1;
    en    = 1'b1;

    // reset held with PU/EN high: outputs stay low
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("rst_clklf", 32'(clklf), 32'd0);
      chk("rst_ready", 32'(lf_ready), 32'd0);
    end
    chk("rst_state", 32'(dut.state), 32'(ST_OFF));

    pu    = 1'b0;
    en    = 1'b0;
    rst_n = 1'b1;
    cyc(3);
    chk("idle_state", 32'(dut.state), 32'(ST_OFF));
    chk("idle_ready", 32'(lf_ready), 32'd0);

    // PU/EN raised: pu_s @2, STARTUP @3, lf_ready @11, first rise @15, period 8.
    // EN dropped after 32 -> rises @39/@47 suppressed; EN raised after 50 -> rise @55.
    // PU dropped after 63 (CLKLF high) -> OFF @66.
    pu = 1'b1;
    en = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      cyc(1);
      exp_lf = (e >= 11) && (e <= 65);
      exp_ck = 1'b0;
      if (e >= 15 && e <= 65) begin
        ph     = (e - 15) % 8;
        r      = e - ph;
        exp_ck = (ph < 4) && (r != 39) && (r != 47);
      end
      chk($sformatf("run_clklf_e%0d", e), 32'(clklf), 32'(exp_ck));
      chk($sformatf("run_ready_e%0d", e), 32'(lf_ready), 32'(exp_lf));
      if (e == 1)  chk("pu_s_e1", 32'(dut.pu_s), 32'd0);
      if (e == 2)  chk("pu_s_e2", 32'(dut.pu_s), 32'd1);
      if (e == 2)  chk("state_e2", 32'(dut.state), 32'(ST_OFF));
      if (e == 3)  chk("state_e3", 32'(dut.state), 32'(ST_STARTUP));
      if (e == 3)  chk("pu_cnt_e3", 32'(dut.pu_cnt), 32'd0);
      if (e == 10) chk("pu_cnt_e10", 32'(dut.pu_cnt), 32'd7);
      if (e == 11) chk("state_e11", 32'(dut.state), 32'(ST_RUN));
      if (e == 11) chk("div_cnt_e11", 32'(dut.div_cnt), 32'd0);
      if (e == 66) begin
        chk("off_state", 32'(dut.state), 32'(ST_OFF));
        chk("off_div_cnt", 32'(dut.div_cnt), 32'd0);
        chk("off_pu_cnt", 32'(dut.pu_cnt), 32'd0);
        chk("off_phase", 32'(dut.phase), 32'd0);
      end
      if (e == 32) en = 1'b0;
      if (e == 50) en = 1'b1;
      if (e == 63) pu = 1'b0;
    end

    // PU raised then dropped after 6: STARTUP @3, pu_s low @8, OFF @9
    pu = 1'b1;
    for (int f = 1; f <= 12; f++) begin
      cyc(1);
      chk($sformatf("abort_ready_f%0d", f), 32'(lf_ready), 32'd0);
      if (f == 8) chk("abort_state_f8", 32'(dut.state), 32'(ST_STARTUP));
      if (f == 9) chk("abort_state_f9", 32'(dut.state), 32'(ST_OFF));
      if (f == 6) pu = 1'b0;
    end

    // re-raised: the full 8-cycle settling is counted again
    pu = 1'b1;
    for (int g = 1; g <= 16; g++) begin
      cyc(1);
      chk($sformatf("retry_ready_g%0d", g), 32'(lf_ready), 32'(g >= 11));
      chk($sformatf("retry_clklf_g%0d", g), 32'(clklf), 32'(g >= 15));
      if (g == 11) chk("retry_state_g11", 32'(dut.state), 32'(ST_RUN));
    end

    // asynchronous reset while CLKLF is high
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clklf", 32'(clklf), 32'd0);
    chk("arst_ready", 32'(lf_ready), 32'd0);
    chk("arst_state", 32'(dut.state), 32'(ST_OFF));
    chk("arst_pu_s", 32'(dut.pu_s), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
